// File: rtl/pc_fetch_if.sv
// pc_fetch_if: fetch unit bus to decode, jump selector and instruction memory
interface pc_fetch_if;
    logic [31:0] newdir;
    logic        stall;
    logic        instr_ack;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] pc;
    logic [31:0] pcadded;
    logic [31:0] instr;
    logic        instr_valid;
    logic [27:0] fjump;
    logic        misalign;
    modport master (
        input  newdir, stall, instr_ack, imem_ready, imem_rdata,
        output imem_req, imem_addr, pc, pcadded, instr, instr_valid, fjump, misalign
    );
    modport slave (
        output newdir, stall, instr_ack, imem_ready, imem_rdata,
        input  imem_req, imem_addr, pc, pcadded, instr, instr_valid, fjump, misalign
    );
endinterface

// File: rtl/pc_fetch.sv
// pc_fetch: program counter and instruction fetch with decode accept handshake
module pc_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic clk,
    input logic reset,
    pc_fetch_if.master bus
);
    typedef enum logic [1:0] {FETCH, ISSUE, HALT} state_t;
    state_t state;
    logic [31:0] pc_q, instr_q;
    logic req_q, valid_q, misalign_q;
    wire accept = bus.instr_ack && !bus.stall;
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= FETCH;
            pc_q       <= RESET_PC;
            instr_q    <= '0;
            misalign_q <= 1'b0;
            req_q      <= 1'b1;
            valid_q    <= 1'b0;
        end else if (state == FETCH && bus.imem_ready) begin
            instr_q <= bus.imem_rdata;
            state   <= ISSUE;
            req_q   <= 1'b0;
            valid_q <= 1'b1;
        end else if (state == ISSUE && accept) begin
            // an unaligned target parks the unit until reset
            if (bus.newdir[1:0] == 2'b00) begin
                pc_q    <= bus.newdir;
                state   <= FETCH;
                req_q   <= 1'b1;
                valid_q <= 1'b0;
            end else begin
                misalign_q <= 1'b1;
                state      <= HALT;
                req_q      <= 1'b0;
                valid_q    <= 1'b0;
            end
        end
    end
    assign bus.imem_req    = req_q;
    assign bus.imem_addr   = pc_q;
    assign bus.pc          = pc_q;
    assign bus.pcadded     = pc_q + 32'd4;
    assign bus.instr       = instr_q;
    assign bus.instr_valid = valid_q;
    assign bus.fjump       = {instr_q[25:0], 2'b00};
    assign bus.misalign    = misalign_q;
endmodule

// File: doc/pc_fetch.md
# pc_fetch

Program-counter and instruction-fetch unit for the single-issue MIPS datapath. It holds the architectural PC and fetches the instruction at that PC from instruction memory using a ready handshake. It presents the instruction, `pcadded` (PC+4) and the pre-shifted jump field `fjump` to decode and the jump selector. It then loads the selector's `newdir` as the next PC once decode accepts the instruction.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset. Must be word-aligned, i.e. bits [1:0] = 0.

Ports:
- `clk`  in  1  the block's single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `newdir`  in  32  next PC chosen by the jump selector; sampled only on the accept edge.
- `stall`  in  1  pipeline hold; blocks the PC update while high.
- `instr_ack`  in  1  decode consumes the presented instruction.
- `imem_ready`  in  1  instruction memory has valid `imem_rdata` this cycle.
- `imem_rdata`  in  32  instruction word from memory.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  32  fetch address; always equals `pc`.
- `pc`  out  32  current PC register.
- `pcadded`  out  32  `pc + 4`, modulo 2^32.
- `instr`  out  32  captured instruction register.
- `instr_valid`  out  1  `instr` is valid and awaiting acceptance.
- `fjump`  out  28  `{instr[25:0], 2'b00}`.
- `misalign`  out  1  sticky flag set when an unaligned `newdir` was accepted.

## Operation
FSM states: FETCH, ISSUE, HALT.

FETCH:
- `imem_req`=1, `instr_valid`=0.
- On an edge with `imem_ready`=1: `instr` <= `imem_rdata`, then go to ISSUE.
- Otherwise stay in FETCH. `imem_req` is held and `pc` is unchanged.

ISSUE:
- `imem_req`=0, `instr_valid`=1.
- Accept event = `instr_ack`=1 and `stall`=0 on the same edge.
- On accept with `newdir[1:0]`==0: `pc` <= `newdir`, then go to FETCH.
- On accept with `newdir[1:0]`!=0: `pc` is unchanged, `misalign` <= 1, then go to HALT.
- `instr_ack` with `stall`=1 is ignored. The state and `instr` are held, and decode must re-assert the ack.

HALT:
- `imem_req`=0, `instr_valid`=0.
- Only `reset` exits this state.

Combinational outputs:
- `pcadded` and `fjump` are pure functions of `pc` and `instr`.
- `imem_addr` = `pc`.
- `imem_req` and `instr_valid` are decoded from state only; they have no combinational path from inputs.

Other rules:
- `imem_ready` is ignored outside FETCH.
- `newdir` is ignored outside the accept edge.

Reset (synchronous, wins over every other event on the same edge):
- State → FETCH, `pc` = `RESET_PC`, `instr` = 0, `misalign` = 0.
- Outputs immediately after the reset edge: `imem_req`=1, `instr_valid`=0, `imem_addr`=`RESET_PC`, `pcadded`=`RESET_PC`+4, `fjump`=0.
- A reset arriving mid-fetch abandons the outstanding request. A response arriving in the same cycle as reset is dropped.

Arithmetic:
- `pcadded` wraps: `pc`=32'hFFFF_FFFC gives `pcadded`=32'h0000_0000.

## Timing
- Fetch latency: the instruction is captured on the edge where `imem_req`&`imem_ready` holds. `instr_valid` rises in the following cycle.
- Minimum throughput is 2 cycles per instruction. This requires `imem_ready`=1 in the FETCH cycle and accept in the first ISSUE cycle.
- PC update: after the accept edge, `pc` and `imem_addr` show `newdir` in the same cycle that `imem_req` re-asserts.
- Each cycle spent in FETCH with `imem_ready`=0 adds one cycle of latency.
- Each ISSUE cycle without an accept adds one cycle; `instr` is stable throughout.
- `misalign` rises the cycle after the faulting accept edge and stays high until reset.

## Test plan
- Reset and fetch: assert `reset` for 1 cycle with `RESET_PC`=0.
  - Required: next cycle `imem_req`=1, `imem_addr`=0, `pcadded`=4.
  - Then `imem_ready`=1 with `imem_rdata`=32'h0800_0010 → next cycle `instr_valid`=1 and `fjump`=28'h000_0040.
- Sequential flow: ack with `newdir`=`pcadded` every ISSUE cycle.
  - Required: `imem_addr` sequence 0, 4, 8, 12, with exactly one ISSUE cycle between fetches.
- Wait and stall: hold `imem_ready`=0 for 3 cycles, then assert `stall`=1 with `instr_ack`=1 for 2 cycles.
  - Required: `pc` held the whole time and `instr_valid` held high while stalled.
  - When `stall` drops: `pc` loads `newdir`=32'h0040_0020.
- Wrap-around: accept `newdir`=32'hFFFF_FFFC.
  - Required: `pcadded`=0, then accept `newdir`=0 → `pc`=0.
- Misaligned jump: accept `newdir`=32'h0000_0102.
  - Required: `misalign`=1, `pc` unchanged, and `imem_req`=0 permanently, ignoring further acks.
  - After `reset`: `misalign`=0 and fetch resumes at `RESET_PC`.
- Reset mid-operation: assert `reset` on the same edge as `imem_ready`=1 in FETCH, and again on the same edge as an accept in ISSUE.
  - Required in both cases: `instr`=0, `pc`=`RESET_PC`, state FETCH, and `newdir` not loaded.
